// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exception_sequencer
// Description : Sequences entry into and exit from the undefined-opcode
//               handler. It latches the faulting PC/opcode, flushes
//               ID/EX/MEM, drains the pipeline, redirects fetch to the
//               handler and resumes at EPC+1 on eret. A second exception
//               raised inside the handler parks the block in FAULT until
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'd1000,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excep_flag,
    input  logic [31:0] ID_PC,
    input  logic [6:0]  ID_opcode,
    input  logic        eret,
    output logic        id_flush,
    output logic        EX_FLUSH,
    output logic        MEM_FLUSH,
    output logic        stall_fetch,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic [31:0] EPC,
    output logic [6:0]  cause,
    output logic        in_handler,
    output logic        double_fault,
    output logic [7:0]  excep_count
);

    // The drain counter is loaded with DRAIN_CYCLES-1 and the exit test is
    // "counter == 0", so the DRAIN state lasts exactly DRAIN_CYCLES cycles.
    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] c_COUNT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLUSH    = 3'd1,
        S_DRAIN    = 3'd2,
        S_REDIRECT = 3'd3,
        S_HANDLER  = 3'd4,
        S_RETURN   = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_drain_cnt;
    logic [31:0] r_epc;
    logic [6:0]  r_cause;
    logic [7:0]  r_excep_count;
    logic        r_id_flush;
    logic        r_ex_flush;
    logic        r_mem_flush;
    logic        r_stall_fetch;
    logic        r_pc_load;
    logic [31:0] r_pc_target;
    logic        r_in_handler;
    logic        r_double_fault;

    // Next-state selection; excep_flag wins over eret inside the handler.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (excep_flag) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == 4'd0) begin
                    w_next_state = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                w_next_state = S_HANDLER;
            end
            S_HANDLER: begin
                if (excep_flag) begin
                    w_next_state = S_FAULT;
                end else if (eret) begin
                    w_next_state = S_RETURN;
                end
            end
            S_RETURN: begin
                w_next_state = S_IDLE;
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, latched exception info and outputs registered from next state,
    // so every output is a flop and no input reaches an output directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_drain_cnt    <= 4'd0;
            r_epc          <= 32'd0;
            r_cause        <= 7'd0;
            r_excep_count  <= 8'd0;
            r_id_flush     <= 1'b0;
            r_ex_flush     <= 1'b0;
            r_mem_flush    <= 1'b0;
            r_stall_fetch  <= 1'b0;
            r_pc_load      <= 1'b0;
            r_pc_target    <= 32'd0;
            r_in_handler   <= 1'b0;
            r_double_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Exception info is captured only on acceptance from IDLE.
            if (r_state == S_IDLE && excep_flag) begin
                r_epc   <= ID_PC;
                r_cause <= ID_opcode;
                if (r_excep_count != c_COUNT_MAX) begin
                    r_excep_count <= r_excep_count + 8'd1;
                end
            end

            if (r_state == S_FLUSH) begin
                r_drain_cnt <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN && r_drain_cnt != 4'd0) begin
                r_drain_cnt <= r_drain_cnt - 4'd1;
            end

            r_id_flush     <= (w_next_state == S_FLUSH) ||
                              (w_next_state == S_RETURN) ||
                              (w_next_state == S_FAULT);
            r_ex_flush     <= (w_next_state == S_FLUSH) ||
                              (w_next_state == S_FAULT);
            r_mem_flush    <= (w_next_state == S_FLUSH) ||
                              (w_next_state == S_FAULT);
            r_stall_fetch  <= (w_next_state == S_FLUSH) ||
                              (w_next_state == S_DRAIN) ||
                              (w_next_state == S_FAULT);
            r_pc_load      <= (w_next_state == S_REDIRECT) ||
                              (w_next_state == S_RETURN);
            r_in_handler   <= (w_next_state == S_HANDLER);
            r_double_fault <= (w_next_state == S_FAULT);

            // EPC is stable while in HANDLER, so EPC+1 is ready for RETURN.
            if (w_next_state == S_REDIRECT) begin
                r_pc_target <= HANDLER_ADDR;
            end else if (w_next_state == S_RETURN) begin
                r_pc_target <= r_epc + 32'd1;
            end else begin
                r_pc_target <= 32'd0;
            end
        end
    end

    assign id_flush     = r_id_flush;
    assign EX_FLUSH     = r_ex_flush;
    assign MEM_FLUSH    = r_mem_flush;
    assign stall_fetch  = r_stall_fetch;
    assign pc_load      = r_pc_load;
    assign pc_target    = r_pc_target;
    assign EPC          = r_epc;
    assign cause        = r_cause;
    assign in_handler   = r_in_handler;
    assign double_fault = r_double_fault;
    assign excep_count  = r_excep_count;

endmodule
`default_nettype wire
